// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control unit: Moore FSM that sequences each instruction
// through fetch, decode, execute, memory and writeback states, plus a
// retired-instruction counter.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   op         opcode from the instruction register (instr[31:26])
//   funct      R-type function field (instr[5:0])
//   zero       ALU zero flag, same cycle
//   iord       memory address select (0=PC, 1=ALUOut)
//   irwrite    instruction register write enable
//   memwrite   data memory write enable
//   regwrite   register file write enable
//   pcen       PC enable = pcwrite | (branch & zero)
//   regdst, memtoreg, alusrca  datapath mux selects
//   alusrcb    ALU B select (00=rt, 01=4, 10=signimm, 11=signimm<<2)
//   pcsrc      next-PC select (00=ALU, 01=ALUOut, 10=jump target)
//   alucontrol ALU operation
//   ZeroExt    result select (00=ALU, 01=lui, 10=xori)
//   state      current FSM state (debug)
//   instret    retired-instruction count, wraps
module multicycle_controller #(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  output logic                 iord,
  output logic                 irwrite,
  output logic                 memwrite,
  output logic                 regwrite,
  output logic                 pcen,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic [2:0]           alucontrol,
  output logic [1:0]           ZeroExt,
  output logic [3:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    XORIWB = 4'd12,
    LUIWB  = 4'd13
  } state_t;

  state_t state_q;
  state_t next_state;
  logic   pcwrite;
  logic   branch;
  logic   retire_c;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= next_state;
  end

  // Retired-instruction counter; bumps on the edge leaving a terminal state
  always_ff @(posedge clk) begin
    if (reset)         instret <= '0;
    else if (retire_c) instret <= instret + INSTRET_W'(1);
  end

  // Next-state and Moore output decode
  always_comb begin
    next_state = FETCH;
    iord       = 1'b0;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = ALU_AND;
    ZeroExt    = 2'b00;
    retire_c   = 1'b0;

    case (state_q)
      FETCH: begin
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        irwrite    = 1'b1;
        pcwrite    = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXEC;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          OP_XORI:      next_state = XORIWB;
          OP_LUI:       next_state = LUIWB;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
        next_state = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord       = 1'b1;
        next_state = MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        retire_c = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        retire_c = 1'b1;
      end
      EXEC: begin
        alusrca = 1'b1;
        case (funct)
          6'b100000: alucontrol = ALU_ADD;
          6'b100010: alucontrol = ALU_SUB;
          6'b100100: alucontrol = ALU_AND;
          6'b100101: alucontrol = ALU_OR;
          6'b101010: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
        next_state = ALUWB;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        retire_c = 1'b1;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        retire_c   = 1'b1;
      end
      ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
        next_state = ADDIWB;
      end
      ADDIWB: begin
        regwrite = 1'b1;
        retire_c = 1'b1;
      end
      JUMP: begin
        pcsrc    = 2'b10;
        pcwrite  = 1'b1;
        retire_c = 1'b1;
      end
      XORIWB: begin
        regwrite = 1'b1;
        ZeroExt  = 2'b10;
        retire_c = 1'b1;
      end
      LUIWB: begin
        regwrite = 1'b1;
        ZeroExt  = 2'b01;
        retire_c = 1'b1;
      end
      default: next_state = FETCH;
    endcase

    // Reset abandons the current instruction: no writes, outputs look like FETCH
    if (reset) begin
      next_state = FETCH;
      iord       = 1'b0;
      irwrite    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b01;
      pcsrc      = 2'b00;
      alucontrol = ALU_ADD;
      ZeroExt    = 2'b00;
      retire_c   = 1'b0;
    end
  end

  assign pcen  = pcwrite | (branch & zero);
  assign state = state_q;

endmodule
